// File: rtl/axil_arbiter2.sv
// axil_arbiter2: two-master AXI4-Lite arbiter in front of the core's single data-memory bus.
// Master 0 is the mriscvcore memory interface. Master 1 is the DMA/debug port.
// The read and write channels are arbitrated independently. A grant is held from the
// address handshake through the response handshake, so the slave side has at most one
// read and one write transaction in flight.
//
// Parameters
//   PRIO_MODE    0 = round-robin (the master not granted last wins a tie)
//                1 = fixed priority (m0 always wins a tie)
//
// Ports
//   clk, rst             system clock; asynchronous active-high reset
//   mX_AR*/mX_R*         read address / read data channel of master X (X = 0, 1)
//   mX_AW*/mX_W*/mX_B*   write address / data / response channel of master X
//   s_*                  slave-side channels, muxed from the granted master
//   rd_grant, wr_grant   one-hot owner of each channel; 00 while that channel is idle
//
// The *data ports on the AR and AW channels carry the address.
module axil_arbiter2 #(
   parameter int PRIO_MODE = 0
) (
   input  logic        clk,
   input  logic        rst,
   // master 0
   input  logic [31:0] m0_ARdata,
   input  logic [2:0]  m0_ARprot,
   input  logic        m0_ARvalid,
   output logic        m0_ARready,
   output logic [31:0] m0_Rdata,
   output logic        m0_Rvalid,
   input  logic        m0_RReady,
   input  logic [31:0] m0_AWdata,
   input  logic [2:0]  m0_AWprot,
   input  logic        m0_AWvalid,
   output logic        m0_AWready,
   input  logic [31:0] m0_Wdata,
   input  logic [3:0]  m0_Wstrb,
   input  logic        m0_Wvalid,
   output logic        m0_Wready,
   output logic        m0_Bvalid,
   input  logic        m0_Bready,
   // master 1
   input  logic [31:0] m1_ARdata,
   input  logic [2:0]  m1_ARprot,
   input  logic        m1_ARvalid,
   output logic        m1_ARready,
   output logic [31:0] m1_Rdata,
   output logic        m1_Rvalid,
   input  logic        m1_RReady,
   input  logic [31:0] m1_AWdata,
   input  logic [2:0]  m1_AWprot,
   input  logic        m1_AWvalid,
   output logic        m1_AWready,
   input  logic [31:0] m1_Wdata,
   input  logic [3:0]  m1_Wstrb,
   input  logic        m1_Wvalid,
   output logic        m1_Wready,
   output logic        m1_Bvalid,
   input  logic        m1_Bready,
   // slave side
   output logic [31:0] s_ARdata,
   output logic [2:0]  s_ARprot,
   output logic        s_ARvalid,
   input  logic        s_ARready,
   input  logic [31:0] s_Rdata,
   input  logic        s_Rvalid,
   output logic        s_RReady,
   output logic [31:0] s_AWdata,
   output logic [2:0]  s_AWprot,
   output logic        s_AWvalid,
   input  logic        s_AWready,
   output logic [31:0] s_Wdata,
   output logic [3:0]  s_Wstrb,
   output logic        s_Wvalid,
   input  logic        s_Wready,
   input  logic        s_Bvalid,
   output logic        s_Bready,
   // grant status
   output logic [1:0]  rd_grant,
   output logic [1:0]  wr_grant
);

   // state  | meaning
   // R_IDLE | no read owner; arbitrate among ARvalid requests
   // R_ADDR | owner's AR channel routed to the slave
   // R_DATA | slave R channel routed back to the owner
   // W_IDLE | no write owner; arbitrate among AWvalid/Wvalid requests
   // W_ADDR | owner's AW and W routed concurrently, each retired once
   // W_RESP | slave B channel routed back to the owner
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;

   rd_state_t rd_state_q, rd_state_d;
   wr_state_t wr_state_q, wr_state_d;
   logic      rd_owner_q, rd_owner_d;   // 0 = m0, 1 = m1
   logic      last_rd_q, last_rd_d;
   logic      wr_owner_q, wr_owner_d;
   logic      last_wr_q, last_wr_d;
   logic      aw_done_q, aw_done_d;
   logic      w_done_q, w_done_d;

   // On a tie, fixed priority always picks m0; round-robin picks the master not granted last.
   function automatic logic arb_pick(input logic req0, input logic req1, input logic last);
      if (req0 && req1) begin
         return (PRIO_MODE != 0) ? 1'b0 : ~last;
      end
      return req1 & ~req0;
   endfunction

   logic ar_valid_sel, r_ready_sel;
   logic aw_valid_sel, w_valid_sel, b_ready_sel;
   logic aw_hs, w_hs;
   logic wr_req0, wr_req1;

   assign ar_valid_sel = rd_owner_q ? m1_ARvalid : m0_ARvalid;
   assign r_ready_sel  = rd_owner_q ? m1_RReady  : m0_RReady;
   assign aw_valid_sel = wr_owner_q ? m1_AWvalid : m0_AWvalid;
   assign w_valid_sel  = wr_owner_q ? m1_Wvalid  : m0_Wvalid;
   assign b_ready_sel  = wr_owner_q ? m1_Bready  : m0_Bready;

   // A write request is either half of the transaction, so W may arrive before AW.
   assign wr_req0 = m0_AWvalid | m0_Wvalid;
   assign wr_req1 = m1_AWvalid | m1_Wvalid;

   assign m0_Rdata = s_Rdata;
   assign m1_Rdata = s_Rdata;

   assign rd_grant = (rd_state_q == R_IDLE) ? 2'b00 : {rd_owner_q, ~rd_owner_q};
   assign wr_grant = (wr_state_q == W_IDLE) ? 2'b00 : {wr_owner_q, ~wr_owner_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state_q <= R_IDLE;
         rd_owner_q <= 1'b0;
         last_rd_q  <= 1'b1;
         wr_state_q <= W_IDLE;
         wr_owner_q <= 1'b0;
         last_wr_q  <= 1'b1;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_owner_q <= rd_owner_d;
         last_rd_q  <= last_rd_d;
         wr_state_q <= wr_state_d;
         wr_owner_q <= wr_owner_d;
         last_wr_q  <= last_wr_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
      end
   end

   // Read channel. Slave data buses are forced to zero outside R_ADDR so that an idle
   // bus does not show whatever the masters happen to drive.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_owner_d = rd_owner_q;
      last_rd_d  = last_rd_q;
      s_ARdata   = '0;
      s_ARprot   = '0;
      s_ARvalid  = 1'b0;
      s_RReady   = 1'b0;
      m0_ARready = 1'b0;
      m1_ARready = 1'b0;
      m0_Rvalid  = 1'b0;
      m1_Rvalid  = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            if (m0_ARvalid || m1_ARvalid) begin
               rd_owner_d = arb_pick(m0_ARvalid, m1_ARvalid, last_rd_q);
               rd_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            s_ARdata   = rd_owner_q ? m1_ARdata : m0_ARdata;
            s_ARprot   = rd_owner_q ? m1_ARprot : m0_ARprot;
            s_ARvalid  = ar_valid_sel;
            m0_ARready = ~rd_owner_q & s_ARready;
            m1_ARready = rd_owner_q & s_ARready;
            if (ar_valid_sel && s_ARready) begin
               rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            s_RReady  = r_ready_sel;
            m0_Rvalid = ~rd_owner_q & s_Rvalid;
            m1_Rvalid = rd_owner_q & s_Rvalid;
            if (s_Rvalid && r_ready_sel) begin
               last_rd_d  = rd_owner_q;
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   // Write channel. aw_done/w_done retire each half independently; the matching
   // valid and ready are suppressed once a half has completed.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_owner_d = wr_owner_q;
      last_wr_d  = last_wr_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      aw_hs      = 1'b0;
      w_hs       = 1'b0;
      s_AWdata   = '0;
      s_AWprot   = '0;
      s_AWvalid  = 1'b0;
      s_Wdata    = '0;
      s_Wstrb    = '0;
      s_Wvalid   = 1'b0;
      s_Bready   = 1'b0;
      m0_AWready = 1'b0;
      m1_AWready = 1'b0;
      m0_Wready  = 1'b0;
      m1_Wready  = 1'b0;
      m0_Bvalid  = 1'b0;
      m1_Bvalid  = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (wr_req0 || wr_req1) begin
               wr_owner_d = arb_pick(wr_req0, wr_req1, last_wr_q);
               wr_state_d = W_ADDR;
            end
         end
         W_ADDR: begin
            s_AWdata   = wr_owner_q ? m1_AWdata : m0_AWdata;
            s_AWprot   = wr_owner_q ? m1_AWprot : m0_AWprot;
            s_AWvalid  = aw_valid_sel & ~aw_done_q;
            s_Wdata    = wr_owner_q ? m1_Wdata : m0_Wdata;
            s_Wstrb    = wr_owner_q ? m1_Wstrb : m0_Wstrb;
            s_Wvalid   = w_valid_sel & ~w_done_q;
            m0_AWready = ~wr_owner_q & ~aw_done_q & s_AWready;
            m1_AWready = wr_owner_q & ~aw_done_q & s_AWready;
            m0_Wready  = ~wr_owner_q & ~w_done_q & s_Wready;
            m1_Wready  = wr_owner_q & ~w_done_q & s_Wready;
            aw_hs      = aw_valid_sel & ~aw_done_q & s_AWready;
            w_hs       = w_valid_sel & ~w_done_q & s_Wready;
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               wr_state_d = W_RESP;
            end else begin
               aw_done_d = aw_done_q | aw_hs;
               w_done_d  = w_done_q | w_hs;
            end
         end
         W_RESP: begin
            s_Bready  = b_ready_sel;
            m0_Bvalid = ~wr_owner_q & s_Bvalid;
            m1_Bvalid = wr_owner_q & s_Bvalid;
            if (s_Bvalid && b_ready_sel) begin
               last_wr_d  = wr_owner_q;
               wr_state_d = W_IDLE;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axil_arbiter2.sv
// Bench for axil_arbiter2: instance 0 is round-robin, instance 1 is fixed priority;
// both see the same inputs. Instance 0 is checked every cycle against a
// transaction-level model; both instances get directed literal checks.
module tb_axil_arbiter2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [31:0] m0_ARdata = '0, m1_ARdata = '0, m0_AWdata = '0, m1_AWdata = '0;
   logic [2:0]  m0_ARprot = '0, m1_ARprot = '0, m0_AWprot = '0, m1_AWprot = '0;
   logic        m0_ARvalid = 1'b0, m1_ARvalid = 1'b0, m0_RReady = 1'b0, m1_RReady = 1'b0;
   logic        m0_AWvalid = 1'b0, m1_AWvalid = 1'b0, m0_Wvalid = 1'b0, m1_Wvalid = 1'b0;
   logic [31:0] m0_Wdata = '0, m1_Wdata = '0;
   logic [3:0]  m0_Wstrb = '0, m1_Wstrb = '0;
   logic        m0_Bready = 1'b0, m1_Bready = 1'b0;
   logic        s_ARready = 1'b0, s_Rvalid = 1'b0, s_AWready = 1'b0, s_Wready = 1'b0, s_Bvalid = 1'b0;
   logic [31:0] s_Rdata = '0;

   logic        m0_ARready [2], m1_ARready [2], m0_Rvalid [2], m1_Rvalid [2];
   logic [31:0] m0_Rdata [2], m1_Rdata [2];
   logic        m0_AWready [2], m1_AWready [2], m0_Wready [2], m1_Wready [2];
   logic        m0_Bvalid [2], m1_Bvalid [2];
   logic [31:0] s_ARdata [2], s_AWdata [2], s_Wdata [2];
   logic [2:0]  s_ARprot [2], s_AWprot [2];
   logic [3:0]  s_Wstrb [2];
   logic        s_ARvalid [2], s_AWvalid [2], s_Wvalid [2], s_RReady [2], s_Bready [2];
   logic [1:0]  rd_grant [2], wr_grant [2];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      axil_arbiter2 #(.PRIO_MODE(g)) u_dut (
         .clk(clk), .rst(rst),
         .m0_ARdata(m0_ARdata), .m0_ARprot(m0_ARprot), .m0_ARvalid(m0_ARvalid),
         .m0_ARready(m0_ARready[g]), .m0_Rdata(m0_Rdata[g]), .m0_Rvalid(m0_Rvalid[g]),
         .m0_RReady(m0_RReady), .m0_AWdata(m0_AWdata), .m0_AWprot(m0_AWprot),
         .m0_AWvalid(m0_AWvalid), .m0_AWready(m0_AWready[g]), .m0_Wdata(m0_Wdata),
         .m0_Wstrb(m0_Wstrb), .m0_Wvalid(m0_Wvalid), .m0_Wready(m0_Wready[g]),
         .m0_Bvalid(m0_Bvalid[g]), .m0_Bready(m0_Bready),
         .m1_ARdata(m1_ARdata), .m1_ARprot(m1_ARprot), .m1_ARvalid(m1_ARvalid),
         .m1_ARready(m1_ARready[g]), .m1_Rdata(m1_Rdata[g]), .m1_Rvalid(m1_Rvalid[g]),
         .m1_RReady(m1_RReady), .m1_AWdata(m1_AWdata), .m1_AWprot(m1_AWprot),
         .m1_AWvalid(m1_AWvalid), .m1_AWready(m1_AWready[g]), .m1_Wdata(m1_Wdata),
         .m1_Wstrb(m1_Wstrb), .m1_Wvalid(m1_Wvalid), .m1_Wready(m1_Wready[g]),
         .m1_Bvalid(m1_Bvalid[g]), .m1_Bready(m1_Bready),
         .s_ARdata(s_ARdata[g]), .s_ARprot(s_ARprot[g]), .s_ARvalid(s_ARvalid[g]),
         .s_ARready(s_ARready), .s_Rdata(s_Rdata), .s_Rvalid(s_Rvalid),
         .s_RReady(s_RReady[g]), .s_AWdata(s_AWdata[g]), .s_AWprot(s_AWprot[g]),
         .s_AWvalid(s_AWvalid[g]), .s_AWready(s_AWready), .s_Wdata(s_Wdata[g]),
         .s_Wstrb(s_Wstrb[g]), .s_Wvalid(s_Wvalid[g]), .s_Wready(s_Wready),
         .s_Bvalid(s_Bvalid), .s_Bready(s_Bready[g]),
         .rd_grant(rd_grant[g]), .wr_grant(wr_grant[g])
      );
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- round-robin transaction model ----------------
   // A channel is either free or owned by one master; a read owner has an address
   // phase then a data phase, a write owner retires AW and W (any order) then B.
   logic m_rd_busy = 1'b0, m_rd_adone = 1'b0, m_rd_own = 1'b0, m_last_rd = 1'b1;
   logic m_wr_busy = 1'b0, m_wr_resp = 1'b0, m_wr_own = 1'b0, m_last_wr = 1'b1;
   logic m_aw_done = 1'b0, m_w_done = 1'b0;

   function automatic logic winner(input logic r0, input logic r1, input logic last);
      if (r0 && r1) return ~last;
      return r0 ? 1'b0 : 1'b1;
   endfunction

   logic o_arv, o_rr, o_awv, o_wv, o_br, wreq0, wreq1, e_aw_hs, e_w_hs;
   logic e_r_addr, e_r_data, e_w_addr, e_w_resp;
   assign o_arv    = m_rd_own ? m1_ARvalid : m0_ARvalid;
   assign o_rr     = m_rd_own ? m1_RReady  : m0_RReady;
   assign o_awv    = m_wr_own ? m1_AWvalid : m0_AWvalid;
   assign o_wv     = m_wr_own ? m1_Wvalid  : m0_Wvalid;
   assign o_br     = m_wr_own ? m1_Bready  : m0_Bready;
   assign wreq0    = m0_AWvalid | m0_Wvalid;
   assign wreq1    = m1_AWvalid | m1_Wvalid;
   assign e_r_addr = m_rd_busy & ~m_rd_adone;
   assign e_r_data = m_rd_busy & m_rd_adone;
   assign e_w_addr = m_wr_busy & ~m_wr_resp;
   assign e_w_resp = m_wr_busy & m_wr_resp;
   assign e_aw_hs  = e_w_addr & ~m_aw_done & o_awv & s_AWready;
   assign e_w_hs   = e_w_addr & ~m_w_done & o_wv & s_Wready;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rd_busy <= 1'b0; m_rd_adone <= 1'b0; m_rd_own <= 1'b0; m_last_rd <= 1'b1;
         m_wr_busy <= 1'b0; m_wr_resp <= 1'b0; m_wr_own <= 1'b0; m_last_wr <= 1'b1;
         m_aw_done <= 1'b0; m_w_done <= 1'b0;
      end else begin
         if (!m_rd_busy) begin
            if (m0_ARvalid || m1_ARvalid) begin
               m_rd_busy  <= 1'b1;
               m_rd_adone <= 1'b0;
               m_rd_own   <= winner(m0_ARvalid, m1_ARvalid, m_last_rd);
            end
         end else if (!m_rd_adone) begin
            if (o_arv && s_ARready) m_rd_adone <= 1'b1;
         end else if (s_Rvalid && o_rr) begin
            m_rd_busy <= 1'b0;
            m_last_rd <= m_rd_own;
         end

         if (!m_wr_busy) begin
            if (wreq0 || wreq1) begin
               m_wr_busy <= 1'b1;
               m_wr_own  <= winner(wreq0, wreq1, m_last_wr);
            end
         end else if (!m_wr_resp) begin
            if ((m_aw_done || e_aw_hs) && (m_w_done || e_w_hs)) begin
               m_wr_resp <= 1'b1;
               m_aw_done <= 1'b0;
               m_w_done  <= 1'b0;
            end else begin
               if (e_aw_hs) m_aw_done <= 1'b1;
               if (e_w_hs)  m_w_done  <= 1'b1;
            end
         end else if (s_Bvalid && o_br) begin
            m_wr_busy <= 1'b0;
            m_wr_resp <= 1'b0;
            m_last_wr <= m_wr_own;
         end
      end
   end

   always @(negedge clk) begin
      check("rd_grant", 64'(rd_grant[0]),
            64'(m_rd_busy ? (m_rd_own ? 2'b10 : 2'b01) : 2'b00));
      check("ar_chan", 64'({s_ARvalid[0], s_ARprot[0], s_ARdata[0]}),
            64'(e_r_addr ? {o_arv, (m_rd_own ? m1_ARprot : m0_ARprot),
                            (m_rd_own ? m1_ARdata : m0_ARdata)} : 36'd0));
      check("ar_ready", 64'({m1_ARready[0], m0_ARready[0]}),
            64'({e_r_addr & m_rd_own & s_ARready, e_r_addr & ~m_rd_own & s_ARready}));
      check("r_chan", 64'({m1_Rvalid[0], m0_Rvalid[0], s_RReady[0]}),
            64'({e_r_data & m_rd_own & s_Rvalid, e_r_data & ~m_rd_own & s_Rvalid,
                 e_r_data & o_rr}));
      check("rdata", {m1_Rdata[0], m0_Rdata[0]}, {s_Rdata, s_Rdata});
      check("wr_grant", 64'(wr_grant[0]),
            64'(m_wr_busy ? (m_wr_own ? 2'b10 : 2'b01) : 2'b00));
      check("aw_chan", 64'({s_AWvalid[0], s_AWprot[0], s_AWdata[0]}),
            64'(e_w_addr ? {o_awv & ~m_aw_done, (m_wr_own ? m1_AWprot : m0_AWprot),
                            (m_wr_own ? m1_AWdata : m0_AWdata)} : 36'd0));
      check("w_chan", 64'({s_Wvalid[0], s_Wstrb[0], s_Wdata[0]}),
            64'(e_w_addr ? {o_wv & ~m_w_done, (m_wr_own ? m1_Wstrb : m0_Wstrb),
                            (m_wr_own ? m1_Wdata : m0_Wdata)} : 37'd0));
      check("aw_w_ready", 64'({m1_AWready[0], m0_AWready[0], m1_Wready[0], m0_Wready[0]}),
            64'({e_w_addr & m_wr_own & ~m_aw_done & s_AWready,
                 e_w_addr & ~m_wr_own & ~m_aw_done & s_AWready,
                 e_w_addr & m_wr_own & ~m_w_done & s_Wready,
                 e_w_addr & ~m_wr_own & ~m_w_done & s_Wready}));
      check("b_chan", 64'({m1_Bvalid[0], m0_Bvalid[0], s_Bready[0]}),
            64'({e_w_resp & m_wr_own & s_Bvalid, e_w_resp & ~m_wr_own & s_Bvalid,
                 e_w_resp & o_br}));
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   initial begin
      #1 rst = 1'b1;
      step();
      step();
      check("rst_rd_grant", 64'({rd_grant[1], rd_grant[0]}), 64'd0);
      check("rst_wr_grant", 64'({wr_grant[1], wr_grant[0]}), 64'd0);
      check("rst_s_valids", 64'({s_ARvalid[0], s_AWvalid[0], s_Wvalid[0], s_RReady[0], s_Bready[0]}), 64'd0);
      check("rst_s_ARdata", 64'(s_ARdata[0]), 64'd0);

      // single read from m0
      rst = 1'b0;
      s_ARready = 1'b1; s_Rvalid = 1'b1; s_Rdata = 32'hDEAD_BEEF;
      m0_RReady = 1'b1; m0_ARvalid = 1'b1; m0_ARdata = 32'h0000_0100;
      step();
      samp();
      check("t1_grant", 64'(rd_grant[0]), 64'h1);
      check("t1_s_ARdata", 64'(s_ARdata[0]), 64'h100);
      check("t1_m1_ARready", 64'(m1_ARready[0]), 64'h0);
      step();
      m0_ARvalid = 1'b0;
      samp();
      check("t1_m0_Rvalid", 64'(m0_Rvalid[0]), 64'h1);
      check("t1_m0_Rdata", 64'(m0_Rdata[0]), 64'hDEAD_BEEF);
      check("t1_m1_Rvalid", 64'(m1_Rvalid[0]), 64'h0);
      step();
      samp();
      check("t1_idle", 64'(rd_grant[0]), 64'h0);

      // repeated read ties: round-robin alternates, fixed priority keeps m0
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      m0_ARvalid = 1'b1; m1_ARvalid = 1'b1; m1_RReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         samp();
         check("t2_rr_grant", 64'(rd_grant[0]), (k % 2 == 1) ? 64'h2 : 64'h1);
         check("t2_prio_grant", 64'(rd_grant[1]), 64'h1);
         step();
         step();
      end
      m0_ARvalid = 1'b0; m1_ARvalid = 1'b0;

      // m1 write with W two cycles ahead of AW
      s_AWready = 1'b1; s_Wready = 1'b1; s_Bvalid = 1'b1; m1_Bready = 1'b1;
      step();
      m1_Wvalid = 1'b1; m1_Wdata = 32'h1234_5678; m1_Wstrb = 4'hF;
      step();
      samp();
      check("t3_grant", 64'(wr_grant[0]), 64'h2);
      check("t3_w_first", 64'({s_Wvalid[0], s_AWvalid[0], m1_Wready[0], m0_Wready[0]}), 64'hA);
      step();
      m1_Wvalid = 1'b0; m1_AWvalid = 1'b1; m1_AWdata = 32'h0000_0200;
      samp();
      check("t3_aw_after_w", 64'({s_Wvalid[0], s_AWvalid[0], m1_AWready[0]}), 64'h3);
      check("t3_s_AWdata", 64'(s_AWdata[0]), 64'h200);
      step();
      m1_AWvalid = 1'b0;
      samp();
      check("t3_b", 64'({m1_Bvalid[0], m0_Bvalid[0], s_Bready[0]}), 64'h5);
      step();
      samp();
      check("t3_idle", 64'({wr_grant[0], m1_Bvalid[0]}), 64'h0);

      // m0 reads while m1 writes
      m0_ARvalid = 1'b1; m0_ARdata = 32'h10;
      m1_AWvalid = 1'b1; m1_AWdata = 32'h20; m1_Wvalid = 1'b1; m1_Wdata = 32'hCAFE_0020;
      step();
      samp();
      check("t4_grants", 64'({rd_grant[0], wr_grant[0]}), 64'h6);
      check("t4_addrs", 64'({s_ARdata[0], s_AWdata[0]}), 64'h0000_0010_0000_0020);
      step();
      m0_ARvalid = 1'b0; m1_AWvalid = 1'b0; m1_Wvalid = 1'b0;
      samp();
      check("t4_no_cross", 64'({m0_Rvalid[0], m1_Rvalid[0], m0_Bvalid[0], m1_Bvalid[0]}), 64'h9);
      step();
      samp();
      check("t4_idle", 64'({rd_grant[0], wr_grant[0]}), 64'h0);

      // stalled read response: slave late, then m0 not ready
      s_Rvalid = 1'b0;
      m0_ARvalid = 1'b1; m0_ARdata = 32'h40;
      step();
      m1_ARvalid = 1'b1; m1_ARdata = 32'h80;
      step();
      m0_ARvalid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         samp();
         check("t5_hold_slave", 64'({rd_grant[0], m1_ARready[0]}), 64'h2);
         step();
      end
      s_Rvalid = 1'b1; m0_RReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         samp();
         check("t5_hold_master", 64'({rd_grant[0], m0_Rvalid[0], m1_ARready[0]}), 64'h6);
         step();
      end
      m0_RReady = 1'b1;
      samp();
      check("t5_last_hold", 64'(rd_grant[0]), 64'h1);
      step();
      samp();
      check("t5_idle_gap", 64'(rd_grant[0]), 64'h0);
      step();
      samp();
      check("t5_m1_grant", 64'(rd_grant[0]), 64'h2);
      step();
      m1_ARvalid = 1'b0;
      step();
      samp();
      check("t5_done", 64'(rd_grant[0]), 64'h0);

      // m0 completes a read, then a second read is aborted by reset in R_DATA
      m0_ARvalid = 1'b1; m0_ARdata = 32'h300;
      step();
      step();
      m0_ARvalid = 1'b0;
      step();
      s_Rvalid = 1'b0;
      m0_ARvalid = 1'b1;
      step();
      step();
      m0_ARvalid = 1'b0;
      samp();
      check("t6_in_data", 64'(rd_grant[0]), 64'h1);
      s_Rvalid = 1'b1; m0_RReady = 1'b0;
      #1;
      check("t6_pre_rst_rvalid", 64'(m0_Rvalid[0]), 64'h1);
      #1 rst = 1'b1;
      #1;
      check("t6_async_grant", 64'({rd_grant[0], rd_grant[1]}), 64'h0);
      check("t6_async_outs", 64'({m0_Rvalid[0], s_RReady[0], s_ARvalid[0], m0_ARready[0]}), 64'h0);
      step();
      rst = 1'b0;
      m0_ARvalid = 1'b1; m1_ARvalid = 1'b1; m0_RReady = 1'b1;
      step();
      samp();
      check("t6_first_tie", 64'(rd_grant[0]), 64'h1);
      step();
      m0_ARvalid = 1'b0; m1_ARvalid = 1'b0;
      step();
      step();
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
